// File: rtl/uart_bus_peripheral.sv
// Memory-mapped UART: 8N1 transmitter behind a small TX FIFO, 8N1 receiver
// with a one-byte holding register, and a status register with sticky
// error flags. Data register at 0x0500, status register at 0x0504.
module uart_bus_peripheral #(
    parameter int CLKS_PER_BIT = 434,
    parameter int TX_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        CE_UART,
    input  logic        CE_SR,
    input  logic        UART_WR,
    input  logic        UART_RD,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    input  logic        rx,
    output logic        tx
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W  = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
    localparam int CNT_W  = $clog2(TX_DEPTH + 1);

    localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(TX_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_t;

    // Bus decode; the data register select masks the status select.
    logic bus_push;
    logic bus_rd_data;
    logic bus_rd_stat;

    assign bus_push    = CE_UART & UART_WR;
    assign bus_rd_data = CE_UART & UART_RD;
    assign bus_rd_stat = CE_SR & UART_RD & ~CE_UART;

    // Only the low byte of a write carries data.
    logic unused_wdata;
    assign unused_wdata = ^WriteData[31:8];

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]       fifo_mem [TX_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    logic fifo_empty;
    logic tx_full;
    logic tx_pop;
    logic push_ok;

    assign fifo_empty = (count_reg == '0);
    assign tx_full    = (count_reg == DEPTH_CNT);
    // A full FIFO still takes a byte when the transmitter frees a slot
    // on the same edge.
    assign push_ok    = bus_push & (~tx_full | tx_pop);

    // FIFO storage; no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_reg] <= WriteData[7:0];
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (tx_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_reg + CNT_W'(push_ok) - CNT_W'(tx_pop);
        end
    end

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    uart_state_t       tx_state_reg;
    logic [BAUD_W-1:0] tx_baud_reg;
    logic [2:0]        tx_bit_reg;
    logic [7:0]        tx_shift_reg;
    logic              tx_reg;
    logic              tx_busy;

    // Pop from IDLE, or at the very end of a stop bit so queued bytes
    // follow each other without an idle gap.
    assign tx_pop  = ~fifo_empty &
                     ((tx_state_reg == ST_IDLE) |
                      ((tx_state_reg == ST_STOP) & (tx_baud_reg == BIT_LAST)));
    assign tx_busy = (tx_state_reg != ST_IDLE) | ~fifo_empty;
    assign tx      = tx_reg;

    // Serializer: tx_reg is loaded one edge ahead so each bit starts cleanly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state_reg <= ST_IDLE;
            tx_baud_reg  <= '0;
            tx_bit_reg   <= '0;
            tx_shift_reg <= '0;
            tx_reg       <= 1'b1;
        end else begin
            case (tx_state_reg)
                ST_IDLE: begin
                    tx_reg <= 1'b1;
                    if (tx_pop) begin
                        tx_shift_reg <= fifo_mem[rd_ptr_reg];
                        tx_baud_reg  <= '0;
                        tx_reg       <= 1'b0;
                        tx_state_reg <= ST_START;
                    end
                end
                ST_START: begin
                    if (tx_baud_reg == BIT_LAST) begin
                        tx_baud_reg  <= '0;
                        tx_bit_reg   <= '0;
                        tx_reg       <= tx_shift_reg[0];
                        tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
                        tx_state_reg <= ST_DATA;
                    end else begin
                        tx_baud_reg <= tx_baud_reg + BAUD_W'(1);
                    end
                end
                ST_DATA: begin
                    if (tx_baud_reg == BIT_LAST) begin
                        tx_baud_reg <= '0;
                        if (tx_bit_reg == 3'd7) begin
                            tx_reg       <= 1'b1;
                            tx_state_reg <= ST_STOP;
                        end else begin
                            tx_bit_reg   <= tx_bit_reg + 3'd1;
                            tx_reg       <= tx_shift_reg[0];
                            tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
                        end
                    end else begin
                        tx_baud_reg <= tx_baud_reg + BAUD_W'(1);
                    end
                end
                ST_STOP: begin
                    if (tx_baud_reg == BIT_LAST) begin
                        tx_baud_reg <= '0;
                        if (tx_pop) begin
                            tx_shift_reg <= fifo_mem[rd_ptr_reg];
                            tx_reg       <= 1'b0;
                            tx_state_reg <= ST_START;
                        end else begin
                            tx_reg       <= 1'b1;
                            tx_state_reg <= ST_IDLE;
                        end
                    end else begin
                        tx_baud_reg <= tx_baud_reg + BAUD_W'(1);
                    end
                end
                default: begin
                    tx_reg       <= 1'b1;
                    tx_state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    logic [1:0] sync_reg;
    logic       rx_sync;
    logic       rx_prev_reg;

    assign rx_sync = sync_reg[1];

    // Two-flop synchronizer plus a delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_reg    <= 2'b11;
            rx_prev_reg <= 1'b1;
        end else begin
            sync_reg    <= {sync_reg[0], rx};
            rx_prev_reg <= rx_sync;
        end
    end

    uart_state_t       rx_state_reg;
    logic [BAUD_W-1:0] rx_baud_reg;
    logic [2:0]        rx_bit_reg;
    logic [7:0]        rx_shift_reg;
    logic              rx_stop_sample;
    logic              rx_done;
    logic              rx_bad;

    assign rx_stop_sample = (rx_state_reg == ST_STOP) & (rx_baud_reg == BIT_LAST);
    assign rx_done        = rx_stop_sample & rx_sync;
    assign rx_bad         = rx_stop_sample & ~rx_sync;

    // Deserializer: qualify the start bit at mid-bit, then sample every bit period.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state_reg <= ST_IDLE;
            rx_baud_reg  <= '0;
            rx_bit_reg   <= '0;
            rx_shift_reg <= '0;
        end else begin
            case (rx_state_reg)
                ST_IDLE: begin
                    rx_baud_reg <= '0;
                    if (~rx_sync & rx_prev_reg) begin
                        rx_state_reg <= ST_START;
                    end
                end
                ST_START: begin
                    if (rx_baud_reg == HALF_LAST) begin
                        rx_baud_reg  <= '0;
                        rx_bit_reg   <= '0;
                        rx_state_reg <= rx_sync ? ST_IDLE : ST_DATA;
                    end else begin
                        rx_baud_reg <= rx_baud_reg + BAUD_W'(1);
                    end
                end
                ST_DATA: begin
                    if (rx_baud_reg == BIT_LAST) begin
                        rx_baud_reg  <= '0;
                        rx_shift_reg <= {rx_sync, rx_shift_reg[7:1]};
                        if (rx_bit_reg == 3'd7) begin
                            rx_state_reg <= ST_STOP;
                        end else begin
                            rx_bit_reg <= rx_bit_reg + 3'd1;
                        end
                    end else begin
                        rx_baud_reg <= rx_baud_reg + BAUD_W'(1);
                    end
                end
                ST_STOP: begin
                    if (rx_baud_reg == BIT_LAST) begin
                        rx_baud_reg  <= '0;
                        rx_state_reg <= ST_IDLE;
                    end else begin
                        rx_baud_reg <= rx_baud_reg + BAUD_W'(1);
                    end
                end
                default: begin
                    rx_state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receive holding register and sticky status flags
    // ------------------------------------------------------------------
    logic [7:0] rx_data_reg;
    logic       rx_valid_reg;
    logic       rx_overrun_reg;
    logic       frame_err_reg;
    logic       tx_overflow_reg;

    // Set events take precedence over the read-to-clear side effects.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_data_reg     <= '0;
            rx_valid_reg    <= 1'b0;
            rx_overrun_reg  <= 1'b0;
            frame_err_reg   <= 1'b0;
            tx_overflow_reg <= 1'b0;
        end else begin
            if (rx_done) begin
                rx_data_reg  <= rx_shift_reg;
                rx_valid_reg <= 1'b1;
            end else if (bus_rd_data) begin
                rx_valid_reg <= 1'b0;
            end

            if (rx_done & rx_valid_reg & ~bus_rd_data) begin
                rx_overrun_reg <= 1'b1;
            end else if (bus_rd_stat) begin
                rx_overrun_reg <= 1'b0;
            end

            if (rx_bad) begin
                frame_err_reg <= 1'b1;
            end else if (bus_rd_stat) begin
                frame_err_reg <= 1'b0;
            end

            if (bus_push & tx_full & ~tx_pop) begin
                tx_overflow_reg <= 1'b1;
            end else if (bus_rd_stat) begin
                tx_overflow_reg <= 1'b0;
            end
        end
    end

    // Combinational read mux.
    always_comb begin
        ReadData = '0;
        if (bus_rd_data) begin
            ReadData = {24'b0, rx_data_reg};
        end else if (bus_rd_stat) begin
            ReadData = {26'b0, frame_err_reg, rx_overrun_reg, tx_overflow_reg,
                        tx_full, tx_busy, rx_valid_reg};
        end
    end

endmodule

// File: tb/tb_uart_bus_peripheral.sv
// Directed bench for uart_bus_peripheral at 4 clocks per bit. A free-running
// line monitor decodes every frame seen on tx, recording its byte, its start
// cycle and whether every bit lasted exactly four cycles.
module tb_uart_bus_peripheral;

    localparam int CPB = 4;
    localparam int FRAME_CYC = 10 * CPB;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        CE_UART = 1'b0;
    logic        CE_SR = 1'b0;
    logic        UART_WR = 1'b0;
    logic        UART_RD = 1'b0;
    logic [31:0] WriteData = '0;
    logic [31:0] ReadData;
    logic        rx = 1'b1;
    logic        tx;

    int n_vec = 0;
    int n_err = 0;
    int unsigned cyc = 0;

    logic [7:0]  mon_byte  [$];
    int unsigned mon_start [$];
    bit          mon_ok    [$];

    uart_bus_peripheral #(
        .CLKS_PER_BIT(CPB),
        .TX_DEPTH    (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .CE_UART  (CE_UART),
        .CE_SR    (CE_SR),
        .UART_WR  (UART_WR),
        .UART_RD  (UART_RD),
        .WriteData(WriteData),
        .ReadData (ReadData),
        .rx       (rx),
        .tx       (tx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // tx line monitor
    initial begin : tx_monitor
        logic [9:0]  bits;
        logic        first;
        logic        val;
        bit          shape;
        int unsigned st;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                st = cyc;
                shape = 1'b1;
                bits = '0;
                first = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    for (int j = 0; j < CPB; j++) begin
                        if (!(k == 0 && j == 0)) @(negedge clk);
                        val = tx;
                        if (j == 0) first = val;
                        else if (val !== first) shape = 1'b0;
                        if (j == CPB / 2) bits[k] = val;
                    end
                end
                mon_byte.push_back(bits[8:1]);
                mon_start.push_back(st);
                mon_ok.push_back(shape && bits[0] == 1'b0 && bits[9] == 1'b1);
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic bus_write(input logic [7:0] b);
        @(negedge clk);
        CE_UART = 1'b1;
        UART_WR = 1'b1;
        WriteData = {24'hABCDEF, b};
        $display("[%0d] write data 0x%02h", cyc, b);
        @(posedge clk);
        #1;
        CE_UART = 1'b0;
        UART_WR = 1'b0;
        WriteData = '0;
    endtask

    task automatic bus_read(input bit stat, output logic [31:0] d);
        @(negedge clk);
        if (stat) CE_SR = 1'b1;
        else CE_UART = 1'b1;
        UART_RD = 1'b1;
        #1;
        d = ReadData;
        $display("[%0d] read %s -> 0x%08h", cyc, stat ? "status" : "data", d);
        @(posedge clk);
        #1;
        CE_SR = 1'b0;
        CE_UART = 1'b0;
        UART_RD = 1'b0;
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rx = b[i];
            repeat (CPB - 1) @(negedge clk);
        end
        @(negedge clk);
        rx = stop;
        repeat (CPB - 1) @(negedge clk);
        @(negedge clk);
        rx = 1'b1;
        $display("[%0d] rx frame 0x%02h stop=%0b sent", cyc, b, stop);
    endtask

    task automatic wait_frames(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (mon_byte.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic clear_monitor();
        mon_byte.delete();
        mon_start.delete();
        mon_ok.delete();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (tx !== 1'b1) begin
            n_err++;
            $display("FAIL reset_tx: got %b want 1", tx);
        end
        rst_n = 1'b1;
        bus_read(1'b1, d);
        n_vec++;
        if (d !== 32'h0) begin
            n_err++;
            $display("FAIL reset_status: got 0x%08h want 0x00000000", d);
        end
        bus_read(1'b0, d);
        n_vec++;
        if (d !== 32'h0) begin
            n_err++;
            $display("FAIL reset_data: got 0x%08h want 0x00000000", d);
        end
        clear_monitor();
    endtask

    task automatic test_single_frame();
        logic [31:0] d;
        bit ok;
        clear_monitor();
        bus_write(8'hA5);
        bus_read(1'b1, d);
        n_vec++;
        if (d !== 32'h02) begin
            n_err++;
            $display("FAIL a5_busy: got 0x%08h want 0x00000002", d);
        end
        wait_frames(1, 200, ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL a5_frame_seen: got timeout want 1 frame");
        end else begin
            n_vec++;
            if (mon_byte[0] !== 8'hA5 || mon_ok[0] !== 1'b1) begin
                n_err++;
                $display("FAIL a5_frame: got byte 0x%02h shape_ok %0b want 0xa5 shape_ok 1",
                         mon_byte[0], mon_ok[0]);
            end
        end
        bus_read(1'b1, d);
        n_vec++;
        if (d !== 32'h0) begin
            n_err++;
            $display("FAIL a5_idle: got 0x%08h want 0x00000000", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        bit ok;
        clear_monitor();
        for (int i = 1; i <= 5; i++) bus_write(8'(i));
        bus_write(8'h06);
        bus_read(1'b1, d);
        n_vec++;
        if (d !== 32'h0E) begin
            n_err++;
            $display("FAIL b2b_overflow: got 0x%08h want 0x0000000e", d);
        end
        bus_read(1'b1, d);
        n_vec++;
        if (d !== 32'h06) begin
            n_err++;
            $display("FAIL b2b_overflow_clr: got 0x%08h want 0x00000006", d);
        end
        wait_frames(5, 400, ok);
        repeat (2 * FRAME_CYC) @(negedge clk);
        n_vec++;
        if (!ok || mon_byte.size() != 5) begin
            n_err++;
            $display("FAIL b2b_count: got %0d frames want 5", mon_byte.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_vec++;
                if (mon_byte[i] !== 8'(i + 1) || mon_ok[i] !== 1'b1) begin
                    n_err++;
                    $display("FAIL b2b_frame%0d: got 0x%02h shape_ok %0b want 0x%02h shape_ok 1",
                             i, mon_byte[i], mon_ok[i], i + 1);
                end
            end
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if (mon_start[i + 1] - mon_start[i] != FRAME_CYC) begin
                    n_err++;
                    $display("FAIL b2b_gap%0d: got %0d cycles want %0d",
                             i, mon_start[i + 1] - mon_start[i], FRAME_CYC);
                end
            end
        end
        bus_read(1'b1, d);
        n_vec++;
        if (d !== 32'h0) begin
            n_err++;
            $display("FAIL b2b_idle: got 0x%08h want 0x00000000", d);
        end
    endtask

    task automatic test_rx_byte();
        logic [31:0] d;
        rx_frame(8'h3C, 1'b1);
        repeat (4) @(negedge clk);
        bus_read(1'b1, d);
        n_vec++;
        if (d !== 32'h01) begin
            n_err++;
            $display("FAIL rx_valid: got 0x%08h want 0x00000001", d);
        end
        bus_read(1'b0, d);
        n_vec++;
        if (d !== 32'h3C) begin
            n_err++;
            $display("FAIL rx_data: got 0x%08h want 0x0000003c", d);
        end
        bus_read(1'b1, d);
        n_vec++;
        if (d !== 32'h0) begin
            n_err++;
            $display("FAIL rx_valid_clr: got 0x%08h want 0x00000000", d);
        end
    endtask

    task automatic test_rx_overrun();
        logic [31:0] d;
        rx_frame(8'h11, 1'b1);
        rx_frame(8'h22, 1'b1);
        repeat (4) @(negedge clk);
        bus_read(1'b1, d);
        n_vec++;
        if (d !== 32'h11) begin
            n_err++;
            $display("FAIL ovr_status: got 0x%08h want 0x00000011", d);
        end
        bus_read(1'b1, d);
        n_vec++;
        if (d !== 32'h01) begin
            n_err++;
            $display("FAIL ovr_status_clr: got 0x%08h want 0x00000001", d);
        end
        bus_read(1'b0, d);
        n_vec++;
        if (d !== 32'h22) begin
            n_err++;
            $display("FAIL ovr_data: got 0x%08h want 0x00000022", d);
        end
        bus_read(1'b1, d);
        n_vec++;
        if (d !== 32'h0) begin
            n_err++;
            $display("FAIL ovr_final: got 0x%08h want 0x00000000", d);
        end
    endtask

    task automatic test_frame_error();
        logic [31:0] d;
        rx_frame(8'h55, 1'b0);
        repeat (4) @(negedge clk);
        bus_read(1'b1, d);
        n_vec++;
        if (d !== 32'h20) begin
            n_err++;
            $display("FAIL ferr_status: got 0x%08h want 0x00000020", d);
        end
        bus_read(1'b1, d);
        n_vec++;
        if (d !== 32'h0) begin
            n_err++;
            $display("FAIL ferr_clr: got 0x%08h want 0x00000000", d);
        end
        // The bad byte must not have replaced the last good one.
        bus_read(1'b0, d);
        n_vec++;
        if (d !== 32'h22) begin
            n_err++;
            $display("FAIL ferr_data_kept: got 0x%08h want 0x00000022", d);
        end
    endtask

    task automatic test_glitch();
        logic [31:0] d;
        @(negedge clk);
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        $display("[%0d] rx 1-cycle glitch sent", cyc);
        repeat (60) @(negedge clk);
        bus_read(1'b1, d);
        n_vec++;
        if (d !== 32'h0) begin
            n_err++;
            $display("FAIL glitch_status: got 0x%08h want 0x00000000", d);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] d;
        bit seen;
        int lows;
        clear_monitor();
        bus_write(8'h00);
        bus_write(8'hFF);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL rstmid_start: got no start bit want start within 20 cycles");
        end
        // Two bit periods in: inside DATA, sending bit 1 of 0x00.
        repeat (2 * CPB) @(negedge clk);
        n_vec++;
        if (tx !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_pre: got tx %b want 0", tx);
        end
        rst_n = 1'b0;
        $display("[%0d] reset asserted mid-frame", cyc);
        @(negedge clk);
        n_vec++;
        if (tx !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_tx: got tx %b want 1", tx);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus_read(1'b1, d);
        n_vec++;
        if (d !== 32'h0) begin
            n_err++;
            $display("FAIL rstmid_status: got 0x%08h want 0x00000000", d);
        end
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        n_vec++;
        if (lows != 0) begin
            n_err++;
            $display("FAIL rstmid_quiet: got %0d non-idle cycles want 0", lows);
        end
        clear_monitor();
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_rx_byte();
        test_rx_overrun();
        test_frame_error();
        test_glitch();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_bus_peripheral.md
UART_BUS_PERIPHERAL -- requirements
Module: uart_bus_peripheral

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per UART bit (legal values 4 or greater; even).
REQ-002 SHALL have parameter TX_DEPTH, default 4, meaning TX FIFO entries (power of two).
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-006 SHALL have port CE_UART, input, 1, data register select (address 0x0500).
REQ-007 SHALL have port CE_SR, input, 1, status register select (address 0x0504).
REQ-008 SHALL have port UART_WR, input, 1, bus write strobe.
REQ-009 SHALL have port UART_RD, input, 1, bus read strobe.
REQ-010 SHALL have port WriteData, input, 32, bus write data; only bits [7:0] are used.
REQ-011 SHALL have port ReadData, output, 32, combinational bus read data.
REQ-012 SHALL have port rx, input, 1, asynchronous serial input.
REQ-013 SHALL have port tx, output, 1, registered serial output.

Function
REQ-014 SHALL decode accesses as follows:
- push = CE_UART & UART_WR
- rd_data = CE_UART & UART_RD
- rd_stat = CE_SR & UART_RD & ~CE_UART
- CE_UART has priority over CE_SR.
REQ-015 SHALL drive ReadData combinationally:
- rd_data: {24'b0, rx_data}
- rd_stat: {26'b0, frame_err, rx_overrun, tx_overflow, tx_full, tx_busy, rx_valid} (bits 5..0)
- otherwise: 0.
REQ-016 SHALL, on push with the FIFO not full, write WriteData[7:0] at the tail at the clock edge.
REQ-017 SHALL, on push with the FIFO full and no pop in the same cycle, drop the byte and set sticky tx_overflow.
REQ-018 SHALL accept a push to a full FIFO in a cycle where the TX FSM pops.
REQ-019 SHALL run the TX FSM through IDLE, START, DATA, STOP; each bit lasts exactly CLKS_PER_BIT cycles.
REQ-020 SHALL, in IDLE with the FIFO non-empty, pop the head into a shift register and enter START; the start bit (tx=0) begins on the next cycle.
REQ-021 SHALL send 8 data bits LSB-first in DATA, then tx=1 in STOP.
REQ-022 SHALL, at the end of STOP, go straight to START (with a pop) if the FIFO is non-empty, else go to IDLE; there is no idle gap between queued bytes.
REQ-023 SHALL hold tx=1 in IDLE and STOP.
REQ-024 SHALL assert tx_busy when the TX FSM is not in IDLE or the FIFO is non-empty; tx_full = (count == TX_DEPTH).
REQ-025 SHALL pass rx through a 2-flop synchronizer before any use.
REQ-026 SHALL run the RX FSM through IDLE, START, DATA, STOP, and leave IDLE on a synchronized falling edge.
REQ-027 SHALL, in START, resample at CLKS_PER_BIT/2; if high, treat it as a false start and return to IDLE; if low, proceed.
REQ-028 SHALL sample data bits every CLKS_PER_BIT cycles from mid-start, LSB-first.
REQ-029 SHALL, on a stop sample of 1:
- load rx_data and set rx_valid;
- also set sticky rx_overrun if rx_valid was already 1 and is not being cleared in that cycle (the new byte overwrites).
REQ-030 SHALL, on a stop sample of 0, discard the byte, set sticky frame_err, and return to IDLE.
REQ-031 SHALL clear rx_valid at the edge of rd_data, unless a new byte completes in the same cycle; in that case rx_valid stays 1, rx_data takes the new byte, and no overrun is flagged.
REQ-032 SHALL clear tx_overflow, rx_overrun and frame_err at the edge of rd_stat; a set event in the same cycle wins and leaves the bit at 1.
REQ-033 SHALL run TX and RX fully independently; bus accesses never stall.

Reset
REQ-034 SHALL, when rst_n=0 at a clock edge, set:
- tx=1
- TX and RX FSMs to IDLE
- FIFO empty (pointers and count 0)
- rx_data=0, rx_valid=0
- all sticky flags 0
- baud and bit counters 0
- synchronizer flops to 1.
REQ-035 SHALL abort any frame in progress on reset; tx=1 from the first edge with rst_n=0, and the partial byte is lost.

Verification (CLKS_PER_BIT=4)
REQ-036 SHALL cover: push 0xA5 -> tx low for 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each), then high; tx_busy clears after the stop bit.
REQ-037 SHALL cover: 5 pushes while IDLE (0x01..0x05) -> first popped; 4 queued; none dropped; 5 back-to-back frames with no gap; tx_overflow=0. A 6th push while the FIFO is full, with no pop that cycle -> tx_overflow=1, and status reads 0x0E (busy, full, overflow) until the read clears bit 3.
REQ-038 SHALL cover: drive 0x3C on rx -> status bit0=1; data read returns 0x0000003C; the next status read shows bit0=0.
REQ-039 SHALL cover: two rx bytes 0x11 then 0x22 with no read in between -> rx_data=0x22 and rx_overrun=1; a status read returns 0x11 and the following status read returns 0x01.
REQ-040 SHALL cover: rx frame with the stop bit forced to 0 -> rx_valid stays 0 and frame_err=1; a 1-cycle low glitch shorter than CLKS_PER_BIT/2 -> no byte and no flag.
REQ-041 SHALL cover: rst_n=0 during the DATA state of a TX frame -> tx=1 at the next edge, status=0 after release, and a queued byte is not transmitted.
